piso_shift_tx: RTL and testbench

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

---
 rtl/piso_shift_tx.sv | 90 +++++++++
 tb/tb_piso_shift_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out frame transmitter with a ready/valid load port and a bit-rate strobe.
// Back-to-back frames are gapless when a new word is accepted on the last bit's shift edge.
module piso_shift_tx #(
   parameter int DATA_WIDTH = 8,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                  Clk_In,
   input  logic                  Reset_In,
   input  logic                  Shift_En_In,
   input  logic [DATA_WIDTH-1:0] Data_In,
   input  logic                  Load_Valid_In,
   output logic                  Load_Ready_Out,
   output logic                  Serial_Out,
   output logic                  Frame_Out,
   output logic                  Done_Out
);

   localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam int OUT_IDX = MSB_FIRST ? (DATA_WIDTH - 1) : 0;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t                state_reg;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] shift_next;
   logic [CNT_W-1:0]      cnt_reg;
   logic                  done_reg;
   logic                  in_shift;
   logic                  last_bit;
   logic                  load;

   // Shift one place toward the output end, filling the vacated end with zero.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
         if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_fill
               assign shift_next[gi] = 1'b0;
            end else begin : g_move
               assign shift_next[gi] = shift_reg[gi-1];
            end
         end else begin : g_lsb
            if (gi == DATA_WIDTH - 1) begin : g_fill
               assign shift_next[gi] = 1'b0;
            end else begin : g_move
               assign shift_next[gi] = shift_reg[gi+1];
            end
         end
      end
   endgenerate

   assign in_shift       = (state_reg == ST_SHIFT);
   assign last_bit       = in_shift && (cnt_reg == '0) && Shift_En_In;
   assign Load_Ready_Out = Reset_In && (!in_shift || last_bit);
   assign load           = Load_Valid_In && Load_Ready_Out;

   assign Serial_Out = in_shift && shift_reg[OUT_IDX];
   assign Frame_Out  = in_shift;
   assign Done_Out   = done_reg;

   always_ff @(posedge Clk_In) begin
      if (!Reset_In) begin
         state_reg <= ST_IDLE;
         shift_reg <= '0;
         cnt_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= last_bit;
         if (load) begin
            // A load on the last-bit edge keeps SHIFT, chaining frames without a gap.
            state_reg <= ST_SHIFT;
            shift_reg <= Data_In;
            cnt_reg   <= CNT_LAST;
         end else if (in_shift && Shift_En_In) begin
            if (cnt_reg != '0) begin
               shift_reg <= shift_next;
               cnt_reg   <= cnt_reg - 1'b1;
            end else begin
               state_reg <= ST_IDLE;
               shift_reg <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Random and directed stimulus for piso_shift_tx (both bit orders) against a queue-based frame model.
module tb_piso_shift_tx;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       shift_en;
   logic [7:0] data;
   logic       load_valid;

   logic ready_m, serial_m, frame_m, done_m;
   logic ready_l, serial_l, frame_l, done_l;

   int n_checks = 0;
   int n_errors = 0;

   // Model: bits still to appear on each serial line, in transmit order.
   bit q_msb[$];
   bit q_lsb[$];
   bit busy      = 1'b0;
   bit done_exp  = 1'b0;

   logic obs_msb, obs_lsb, obs_frame, obs_done, obs_ready;

   always #5 clk = ~clk;

   piso_shift_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .Clk_In(clk), .Reset_In(reset_n), .Shift_En_In(shift_en), .Data_In(data),
      .Load_Valid_In(load_valid), .Load_Ready_Out(ready_m), .Serial_Out(serial_m),
      .Frame_Out(frame_m), .Done_Out(done_m)
   );

   piso_shift_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .Clk_In(clk), .Reset_In(reset_n), .Shift_En_In(shift_en), .Data_In(data),
      .Load_Valid_In(load_valid), .Load_Ready_Out(ready_l), .Serial_Out(serial_l),
      .Frame_Out(frame_l), .Done_Out(done_l)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp_v, $time);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, then advance the model.
   task automatic step(input logic rst_n, input logic en, input logic valid, input logic [7:0] d);
      logic exp_ready, exp_last, do_load;
      reset_n    = rst_n;
      shift_en   = en;
      load_valid = valid;
      data       = d;
      #1;
      exp_last  = busy && (q_msb.size() == 1) && en;
      exp_ready = rst_n && (!busy || exp_last);
      check_eq("serial_msb", serial_m, busy ? q_msb[0] : 1'b0);
      check_eq("serial_lsb", serial_l, busy ? q_lsb[0] : 1'b0);
      check_eq("frame_msb", frame_m, busy);
      check_eq("frame_lsb", frame_l, busy);
      check_eq("done_msb", done_m, done_exp);
      check_eq("done_lsb", done_l, done_exp);
      check_eq("ready_msb", ready_m, exp_ready);
      check_eq("ready_lsb", ready_l, exp_ready);
      obs_msb   = serial_m;
      obs_lsb   = serial_l;
      obs_frame = frame_m;
      obs_done  = done_m;
      obs_ready = ready_m;
      @(posedge clk);
      do_load = valid && exp_ready;
      if (!rst_n) begin
         busy     = 1'b0;
         done_exp = 1'b0;
         q_msb.delete();
         q_lsb.delete();
      end else begin
         done_exp = exp_last;
         if (busy && en) begin
            void'(q_msb.pop_front());
            void'(q_lsb.pop_front());
         end
         if (do_load) begin
            q_msb.delete();
            q_lsb.delete();
            for (int i = 0; i < 8; i++) begin
               q_msb.push_back(d[7-i]);
               q_lsb.push_back(d[i]);
            end
            busy = 1'b1;
            $display("LOAD data=%02h t=%0t", d, $time);
         end else if (busy && q_msb.size() == 0) begin
            busy = 1'b0;
         end
         if (exp_last) $display("DONE t=%0t", $time);
      end
      @(negedge clk);
   endtask

   initial begin
      logic [7:0]  word;
      logic [15:0] word16;
      logic [7:0]  c3;
      int          n_frame, n_done;

      reset_n = 1'b0; shift_en = 1'b0; load_valid = 1'b0; data = 8'h00;
      @(posedge clk); @(posedge clk); @(negedge clk);

      // Reset state.
      step(1'b0, 1'b1, 1'b1, 8'h33);
      check_eq("rst_ready", obs_ready, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'h00);
      check_eq("rst_frame", obs_frame, 1'b0);

      // Full-rate 0xA5, MSB first; LSB-first instance sees the same word reversed.
      step(1'b1, 1'b1, 1'b1, 8'hA5);
      word = '0; n_frame = 0; n_done = 0;
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b1, 1'b0, 8'h00);
         word = {word[6:0], obs_msb};
         n_frame += int'(obs_frame);
         n_done  += int'(obs_done);
      end
      step(1'b1, 1'b1, 1'b0, 8'h00);
      n_done += int'(obs_done);
      check_eq("a5_word", word, 8'hA5);
      check_eq("a5_frame_cycles", n_frame, 8);
      check_eq("a5_done_pulses", n_done, 1);
      check_eq("a5_idle_frame", obs_frame, 1'b0);

      // LSB first, 0x01: a single 1 then seven 0s.
      step(1'b1, 1'b1, 1'b1, 8'h01);
      word = '0;
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b1, 1'b0, 8'h00);
         word[k] = obs_lsb;
      end
      check_eq("lsb01_word", word, 8'h01);
      step(1'b1, 1'b0, 1'b0, 8'h00);

      // Strobe every 4th cycle, 0xC3: each bit held 4 cycles.
      c3 = 8'hC3;
      step(1'b1, 1'b0, 1'b1, c3);
      n_frame = 0;
      for (int k = 0; k < 32; k++) begin
         step(1'b1, (k % 4) == 3, 1'b0, 8'h00);
         n_frame += int'(obs_frame);
         if (obs_msb !== c3[7 - k/4]) check_eq("c3_bit", obs_msb, c3[7 - k/4]);
      end
      check_eq("c3_frame_cycles", n_frame, 32);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      check_eq("c3_done", obs_done, 1'b1);

      // Back-to-back 0x0F then 0xF0 with valid held.
      step(1'b1, 1'b1, 1'b1, 8'h0F);
      word16 = '0; n_frame = 0; n_done = 0;
      for (int k = 0; k < 17; k++) begin
         step(1'b1, 1'b1, k < 8, 8'hF0);
         if (k < 16) begin
            word16 = {word16[14:0], obs_msb};
            n_frame += int'(obs_frame);
         end
         n_done += int'(obs_done);
      end
      check_eq("b2b_bits", word16, 16'h0FF0);
      check_eq("b2b_frame_cycles", n_frame, 16);
      check_eq("b2b_done_pulses", n_done, 2);

      // Reset mid-frame of 0xFF after the third bit.
      step(1'b1, 1'b1, 1'b1, 8'hFF);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check_eq("rstmid_ready_low", obs_ready, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'h00);
      check_eq("rstmid_serial", obs_msb, 1'b0);
      check_eq("rstmid_frame", obs_frame, 1'b0);
      check_eq("rstmid_done", obs_done, 1'b0);
      check_eq("rstmid_ready", obs_ready, 1'b1);

      // 0x55 offered mid-frame of 0xAA is held off until the last bit.
      step(1'b1, 1'b1, 1'b1, 8'hAA);
      word = '0;
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b1, 1'b1, 8'h55);
         word = {word[6:0], obs_msb};
         if (k < 7) check_eq("ign_ready_low", obs_ready, 1'b0);
      end
      check_eq("ign_aa_word", word, 8'hAA);
      word = '0;
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b1, 1'b0, 8'h00);
         word = {word[6:0], obs_msb};
      end
      check_eq("ign_55_word", word, 8'h55);
      step(1'b1, 1'b1, 1'b0, 8'h00);

      // Random traffic: varying strobe density, offers and occasional resets.
      for (int k = 0; k < 600; k++) begin
         logic rn, en, vl;
         rn = ($urandom_range(0, 99) >= 2);
         en = (k < 300) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
         vl = ($urandom_range(0, 2) != 0);
         step(rn, en, vl, 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
